// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg
// Shared definitions for the fully-connected layer sequencer.
//   state_t     : FSM state encoding (IDLE, PRIME, ACCUM, WRITE, DONE)
//   CTL_*       : values of the registered {AG_rst, AG_read, ALU_rst} bundle
//   idx_width() : width of a neuron index, never narrower than one bit
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit order of every constant below: {AG_rst, AG_read, ALU_rst}
    localparam logic [2:0] CTL_DEFAULT = 3'b101;
    localparam logic [2:0] CTL_PRIME   = 3'b011;
    localparam logic [2:0] CTL_ACCUM   = 3'b010;
    // Stalled ACCUM cycle or WRITE: nothing read, accumulator untouched
    localparam logic [2:0] CTL_HOLD    = 3'b000;
    // First cycle after WRITE when another neuron follows: clear only
    localparam logic [2:0] CTL_CLEAR   = 3'b001;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if
// Control bundle between the network controller / datapath and the layer
// sequencer.
//   start, abort, stall                  : controller/datapath -> sequencer
//   AG_rst, AG_read, ALU_rst, ALU_en     : sequencer -> address gen / ALU
//   neuron_idx, out_valid, busy, done    : sequencer -> controller
// Modports: master (controller side), slave (sequencer side).
interface mac_sequencer_if #(
    parameter int IDX_W = 1
);
    logic             start;
    logic             abort;
    logic             stall;
    logic             AG_rst;
    logic             AG_read;
    logic             ALU_rst;
    logic             ALU_en;
    logic [IDX_W-1:0] neuron_idx;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, stall,
        input  AG_rst, AG_read, ALU_rst, ALU_en, neuron_idx, out_valid, busy, done
    );

    modport slave (
        input  start, abort, stall,
        output AG_rst, AG_read, ALU_rst, ALU_en, neuron_idx, out_valid, busy, done
    );

endinterface

// File: rtl/sat_down_counter.sv
// sat_down_counter
// Loadable down counter that saturates at zero.
//   clk, reset (async, active-low)
//   load, load_value : synchronous load, wins over everything else
//   enable           : decrement by one
//   hold             : freezes the count even when enable is high
//   zero             : count is zero
module sat_down_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             hold,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !hold && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Sequences one fully-connected layer: primes the address generator and ALU
// pipeline, then runs N_INPUTS MAC cycles for each of N_NEURONS neurons,
// strobing out_valid per neuron and done at the end of the layer.
//   clk, reset (async, active-low)
//   bus (slave) : start/abort/stall in; AG_rst, AG_read, ALU_rst, ALU_en,
//                 neuron_idx, out_valid, busy, done out (all registered)
module mac_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_INPUTS     = 4,
    parameter int N_NEURONS    = 2,
    parameter int PRIME_CYCLES = 2,
    parameter int IDX_W        = idx_width(N_NEURONS)
) (
    input  logic            clk,
    input  logic            reset,
    mac_sequencer_if.slave  bus
);

    localparam int PW = $clog2(PRIME_CYCLES + 1);
    localparam int IW = $clog2(N_INPUTS + 1);

    // Prime counter holds the PRIME cycles still to come after the current one
    localparam logic [PW-1:0]    PRIME_LOAD = PW'(PRIME_CYCLES - 1);
    // Input counter holds the MAC cycles still to be issued
    localparam logic [IW-1:0]    IN_FULL    = IW'(N_INPUTS);
    localparam logic [IW-1:0]    IN_FIRST   = IW'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);

    state_t           state, state_next;
    logic [2:0]       ctl_q, ctl_d;
    logic             alu_en_q, alu_en_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             prime_load, prime_dec, prime_zero;
    logic [PW-1:0]    prime_val;
    logic             in_load, in_dec, in_zero;
    logic [IW-1:0]    in_val;

    sat_down_counter #(.WIDTH(PW)) u_prime_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (prime_load),
        .load_value (prime_val),
        .enable     (prime_dec),
        .hold       (1'b0),
        .zero       (prime_zero)
    );

    sat_down_counter #(.WIDTH(IW)) u_in_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (in_load),
        .load_value (in_val),
        .enable     (in_dec),
        .hold       (bus.stall),
        .zero       (in_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ctl_q       <= CTL_DEFAULT;
            alu_en_q    <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            ctl_q       <= ctl_d;
            alu_en_q    <= alu_en_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Outputs are decoded for the cycle that follows the edge, so every
    // branch describes what the next cycle must look like. A stall seen at
    // an edge therefore turns the following ACCUM cycle into a hold cycle.
    always_comb begin
        state_next  = state;
        ctl_d       = CTL_DEFAULT;
        alu_en_d    = 1'b0;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        prime_load  = 1'b0;
        prime_val   = '0;
        prime_dec   = 1'b0;
        in_load     = 1'b0;
        in_val      = '0;
        in_dec      = 1'b0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                idx_d  = '0;
                if (bus.start && !bus.abort) begin
                    state_next = PRIME;
                    ctl_d      = CTL_PRIME;
                    busy_d     = 1'b1;
                    prime_load = 1'b1;
                    prime_val  = PRIME_LOAD;
                end
            end
            PRIME: begin
                ctl_d = CTL_PRIME;
                if (prime_zero) begin
                    // The first ACCUM cycle already issues a MAC
                    state_next = ACCUM;
                    ctl_d      = CTL_ACCUM;
                    alu_en_d   = 1'b1;
                    in_load    = 1'b1;
                    in_val     = IN_FIRST;
                end else begin
                    prime_dec = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.stall) begin
                    ctl_d = CTL_HOLD;
                end else if (in_zero) begin
                    state_next  = WRITE;
                    ctl_d       = CTL_HOLD;
                    out_valid_d = 1'b1;
                end else begin
                    ctl_d    = CTL_ACCUM;
                    alu_en_d = 1'b1;
                    in_dec   = 1'b1;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_next = DONE;
                    ctl_d      = CTL_DEFAULT;
                    done_d     = 1'b1;
                end else begin
                    // Re-enter ACCUM with a clear-only cycle; no MAC issued yet
                    state_next = ACCUM;
                    ctl_d      = CTL_CLEAR;
                    idx_d      = idx_q + 1'b1;
                    in_load    = 1'b1;
                    in_val     = IN_FULL;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_d     = 1'b0;
                idx_d      = '0;
            end
            default: begin
                state_next = IDLE;
                busy_d     = 1'b0;
                idx_d      = '0;
            end
        endcase

        if (bus.abort) begin
            state_next  = IDLE;
            ctl_d       = CTL_DEFAULT;
            alu_en_d    = 1'b0;
            idx_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            prime_load  = 1'b1;
            prime_val   = '0;
            prime_dec   = 1'b0;
            in_load     = 1'b1;
            in_val      = '0;
            in_dec      = 1'b0;
        end
    end

    assign {bus.AG_rst, bus.AG_read, bus.ALU_rst} = ctl_q;
    assign bus.ALU_en     = alu_en_q;
    assign bus.neuron_idx = idx_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Directed bench for mac_sequencer. A default-configuration instance
// (4 inputs, 2 neurons, 2 prime cycles) and a minimal instance (1/1/1)
// share clock and reset. Stimulus pushes expected out_valid/done strobes
// into per-instance queues; a monitor pops and compares them as they appear.
// Output vectors are packed as
// {busy, AG_rst, AG_read, ALU_rst, ALU_en, out_valid, done, neuron_idx[0]}.
module tb_mac_sequencer;

    typedef struct packed {
        logic       ov;
        logic       dn;
        logic [3:0] idx;
        logic [3:0] macs;
    } exp_t;

    localparam logic [7:0] V_IDLE  = 8'b0101_0000;
    localparam logic [7:0] V_PRIME = 8'b1011_0000;
    localparam logic [7:0] V_MAC0  = 8'b1010_1000;
    localparam logic [7:0] V_WR0   = 8'b1000_0100;
    localparam logic [7:0] V_CLR1  = 8'b1001_0001;
    localparam logic [7:0] V_MAC1  = 8'b1010_1001;
    localparam logic [7:0] V_WR1   = 8'b1000_0101;
    localparam logic [7:0] V_DONE  = 8'b1101_0010;

    localparam logic [7:0] T1_EXP [16] = '{
        V_IDLE, V_PRIME, V_PRIME, V_MAC0, V_MAC0, V_MAC0, V_MAC0, V_WR0,
        V_CLR1, V_MAC1, V_MAC1, V_MAC1, V_MAC1, V_WR1, V_DONE, V_IDLE
    };

    localparam logic [7:0] T6_EXP [6] = '{
        V_IDLE, V_PRIME, V_MAC0, V_WR0, V_DONE, V_IDLE
    };

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mac_sequencer_if #(.IDX_W(1)) bus ();
    mac_sequencer_if #(.IDX_W(1)) bus_s ();

    mac_sequencer #(
        .N_INPUTS     (4),
        .N_NEURONS    (2),
        .PRIME_CYCLES (2),
        .IDX_W        (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mac_sequencer #(
        .N_INPUTS     (1),
        .N_NEURONS    (1),
        .PRIME_CYCLES (1),
        .IDX_W        (1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   start_cyc;
    int   mac_cnt = 0;
    int   mac_cnt_s = 0;
    int   last_done_cyc = -1;
    int   last_done_cyc_s = -1;
    int   done_cnt = 0;
    int   done_times [$];
    exp_t exp_q [$];
    exp_t exp_s_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [7:0] act,
                             input logic [7:0] exp, input logic [7:0] mask);
        check_output(name, int'(act & mask), int'(exp & mask));
    endtask

    task automatic apply_stimulus(input logic st, input logic sl, input logic ab);
        bus.start = st;
        bus.stall = sl;
        bus.abort = ab;
    endtask

    task automatic apply_stimulus_s(input logic st, input logic sl, input logic ab);
        bus_s.start = st;
        bus_s.stall = sl;
        bus_s.abort = ab;
    endtask

    function automatic exp_t mk_exp(input logic is_done, input int idx, input int macs);
        exp_t e;
        e.ov   = !is_done;
        e.dn   = is_done;
        e.idx  = 4'(idx);
        e.macs = 4'(macs);
        return e;
    endfunction

    function automatic logic [7:0] vec_main();
        return {bus.busy, bus.AG_rst, bus.AG_read, bus.ALU_rst, bus.ALU_en,
                bus.out_valid, bus.done, bus.neuron_idx[0]};
    endfunction

    function automatic logic [7:0] vec_s();
        return {bus_s.busy, bus_s.AG_rst, bus_s.AG_read, bus_s.ALU_rst, bus_s.ALU_en,
                bus_s.out_valid, bus_s.done, bus_s.neuron_idx[0]};
    endfunction

    // Scoreboard monitor for the default instance
    always @(negedge clk) begin
        exp_t e;
        if (!bus.busy) mac_cnt = 0;
        else if (bus.ALU_en) mac_cnt++;
        if (bus.out_valid || bus.done) begin
            if (exp_q.size() == 0) begin
                check_output("sb_unexpected_strobe", int'({bus.out_valid, bus.done}), 0);
            end else begin
                e = exp_q.pop_front();
                check_output("sb_strobe", int'({bus.out_valid, bus.done}), int'({e.ov, e.dn}));
                if (e.ov) begin
                    check_output("sb_idx", int'(bus.neuron_idx), int'(e.idx));
                    check_output("sb_macs", mac_cnt, int'(e.macs));
                end
            end
            if (bus.out_valid) mac_cnt = 0;
            if (bus.done) begin
                last_done_cyc = cyc;
                done_cnt++;
                done_times.push_back(cyc);
            end
        end
    end

    // Scoreboard monitor for the minimal instance
    always @(negedge clk) begin
        exp_t e;
        if (!bus_s.busy) mac_cnt_s = 0;
        else if (bus_s.ALU_en) mac_cnt_s++;
        if (bus_s.out_valid || bus_s.done) begin
            if (exp_s_q.size() == 0) begin
                check_output("sbs_unexpected_strobe", int'({bus_s.out_valid, bus_s.done}), 0);
            end else begin
                e = exp_s_q.pop_front();
                check_output("sbs_strobe", int'({bus_s.out_valid, bus_s.done}), int'({e.ov, e.dn}));
                if (e.ov) begin
                    check_output("sbs_idx", int'(bus_s.neuron_idx), int'(e.idx));
                    check_output("sbs_macs", mac_cnt_s, int'(e.macs));
                end
            end
            if (bus_s.out_valid) mac_cnt_s = 0;
            if (bus_s.done) last_done_cyc_s = cyc;
        end
    end

    // Called at the negedge of the cycle in which start is first driven
    task automatic run_layer(input string tag, input bit trace);
        exp_q.push_back(mk_exp(1'b0, 0, 4));
        exp_q.push_back(mk_exp(1'b0, 1, 4));
        exp_q.push_back(mk_exp(1'b1, 1, 0));
        start_cyc     = cyc;
        last_done_cyc = -1;
        if (trace) check_vec({tag, "_c0"}, vec_main(), T1_EXP[0], 8'hFF);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (i == 1) apply_stimulus(1'b0, 1'b0, 1'b0);
            if (trace) begin
                check_vec($sformatf("%s_c%0d", tag, i), vec_main(), T1_EXP[i],
                          (i >= 14) ? 8'hFE : 8'hFF);
            end
        end
        check_output({tag, "_latency"}, last_done_cyc - start_cyc, 14);
        check_output({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus_s(1'b0, 1'b0, 1'b0);
        #12;
        check_vec("reset_vec", vec_main(), V_IDLE, 8'hFF);
        check_vec("reset_vec_s", vec_s(), V_IDLE, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: full layer with cycle trace
        $display("[TB] test 1: full layer, default configuration");
        run_layer("t1", 1'b1);

        // Test 2: three stall cycles during neuron 0
        $display("[TB] test 2: stall during neuron 0");
        @(negedge clk);
        exp_q.push_back(mk_exp(1'b0, 0, 4));
        exp_q.push_back(mk_exp(1'b0, 1, 4));
        exp_q.push_back(mk_exp(1'b1, 1, 0));
        start_cyc     = cyc;
        last_done_cyc = -1;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i >= 5 && i <= 7) begin
                check_output($sformatf("t2_hold_c%0d", i), int'({bus.AG_read, bus.ALU_en}), 0);
            end
            if (i == 8) check_output("t2_resume", int'({bus.AG_read, bus.ALU_en}), 3);
            apply_stimulus(1'b0, (i >= 4 && i <= 6), 1'b0);
        end
        check_output("t2_latency", last_done_cyc - start_cyc, 17);
        check_output("t2_drain", exp_q.size(), 0);

        // Test 3: abort during neuron 1, then a clean layer
        $display("[TB] test 3: abort during neuron 1");
        @(negedge clk);
        exp_q.push_back(mk_exp(1'b0, 0, 4));
        done_cnt = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) apply_stimulus(1'b0, 1'b0, 1'b0);
            if (i == 10) begin
                check_vec("t3_pre_abort", vec_main(), V_MAC1, 8'hFF);
                apply_stimulus(1'b0, 1'b0, 1'b1);
            end
            if (i == 11) begin
                check_vec("t3_after_abort", vec_main(), V_IDLE, 8'hFF);
                apply_stimulus(1'b0, 1'b0, 1'b0);
            end
        end
        repeat (20) @(negedge clk);
        check_output("t3_drain", exp_q.size(), 0);
        check_output("t3_no_done", done_cnt, 0);
        @(negedge clk);
        run_layer("t3_rerun", 1'b0);

        // Test 4: asynchronous reset between edges during PRIME
        $display("[TB] test 4: asynchronous reset during prime");
        @(negedge clk);
        done_cnt = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_vec("t4_in_prime", vec_main(), V_PRIME, 8'hFF);
        #2 reset = 1'b0;
        #1 check_vec("t4_async_reset", vec_main(), V_IDLE, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check_output("t4_no_done", done_cnt, 0);
        check_output("t4_drain", exp_q.size(), 0);

        // Test 5: start held high across two layers
        $display("[TB] test 5: start held high");
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back(mk_exp(1'b0, 0, 4));
            exp_q.push_back(mk_exp(1'b0, 1, 4));
            exp_q.push_back(mk_exp(1'b1, 1, 0));
        end
        done_times.delete();
        start_cyc = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 15) check_output("t5_idle_between", int'(bus.busy), 0);
            if (i == 16) check_output("t5_restart", int'(bus.busy), 1);
            if (i == 30) apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        check_output("t5_done_count", done_times.size(), 2);
        if (done_times.size() == 2) begin
            check_output("t5_first_latency", done_times[0] - start_cyc, 14);
            check_output("t5_spacing", done_times[1] - done_times[0], 15);
        end
        check_output("t5_drain", exp_q.size(), 0);

        // Test 6: minimal configuration
        $display("[TB] test 6: single neuron, single input, single prime cycle");
        @(negedge clk);
        exp_s_q.push_back(mk_exp(1'b0, 0, 1));
        exp_s_q.push_back(mk_exp(1'b1, 0, 0));
        start_cyc       = cyc;
        last_done_cyc_s = -1;
        check_vec("t6_c0", vec_s(), T6_EXP[0], 8'hFF);
        apply_stimulus_s(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) apply_stimulus_s(1'b0, 1'b0, 1'b0);
            check_vec($sformatf("t6_c%0d", i), vec_s(), T6_EXP[i], (i >= 4) ? 8'hFE : 8'hFF);
        end
        check_output("t6_latency", last_done_cyc_s - start_cyc, 4);
        check_output("t6_drain", exp_s_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
